// File: rtl/matmul_engine_if.sv
// Handshake/bus bundle for matmul_engine.
// Ports: start_in/mode_in request, valid_input/X_load element stream, read_n read strobe,
//        busy/ry/finish/sat_flag status and the registered read_data result.
interface matmul_engine_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
);
    logic              start_in;
    logic              mode_in;
    logic              valid_input;
    logic [DATA_W-1:0] X_load;
    logic              read_n;
    logic              busy;
    logic              ry;
    logic [OUT_W-1:0]  read_data;
    logic              finish;
    logic              sat_flag;

    modport master (
        output start_in, mode_in, valid_input, X_load, read_n,
        input  busy, ry, read_data, finish, sat_flag
    );

    modport slave (
        input  start_in, mode_in, valid_input, X_load, read_n,
        output busy, ry, read_data, finish, sat_flag
    );
endinterface

// File: rtl/matmul_engine.sv
// Load/compute/readout engine: result[ROWS][COLS] = X[ROWS][K] * C[K][COLS], unsigned, saturated to OUT_W.
// Latency: ROWS*COLS*K compute cycles after the last X element; read_data valid one cycle after read_n=0.
// Backpressure: loads advance only on valid_input, readout only on read_n=0 while ry=1; others ignored.
// Ports: clk, rst (sync, active-high); bus (slave modport of matmul_engine_if).
module matmul_engine #(
    parameter int ROWS   = 4,
    parameter int K      = 8,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    matmul_engine_if.slave bus
);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(K);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW    = (K    > 1) ? $clog2(K)    : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_C  = 3'd1;
    localparam logic [2:0] S_LOAD_X  = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_READY   = 3'd4;

    logic [2:0]        state_q, state_d;
    // r/k/c are shared: LOAD_C walks (k,c), LOAD_X walks (r,k), COMPUTE walks (r,c,k),
    // READY walks (r,c). Every phase leaves them wrapped back to zero.
    logic [RW-1:0]     r_q;
    logic [KW-1:0]     k_q;
    logic [CW-1:0]     c_q;
    logic [ACC_W-1:0]  acc_q;
    logic              finish_q;
    logic              sat_q;
    logic [OUT_W-1:0]  rdata_q;

    logic [COEF_W-1:0] c_mem_q [K][COLS];
    logic [DATA_W-1:0] x_mem_q [ROWS][K];
    logic [OUT_W-1:0]  res_q   [ROWS][COLS];

    logic              r_last, k_last, c_last;
    logic [ACC_W-1:0]  prod;
    logic [ACC_W-1:0]  acc_d;
    logic              sat;
    logic [OUT_W-1:0]  res_val;

    assign r_last = (r_q == R_LAST);
    assign k_last = (k_q == K_LAST);
    assign c_last = (c_q == C_LAST);

    // Single MAC: the k=0 cycle restarts the sum so no separate clear is needed.
    always_comb begin
        prod    = ACC_W'(x_mem_q[r_q][k_q]) * ACC_W'(c_mem_q[k_q][c_q]);
        acc_d   = (k_q == '0) ? prod : acc_q + prod;
        sat     = |(acc_d >> OUT_W);
        res_val = sat ? '1 : acc_d[OUT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.start_in) state_d = bus.mode_in ? S_LOAD_C : S_LOAD_X;
            S_LOAD_C:  if (bus.valid_input && k_last && c_last) state_d = S_IDLE;
            S_LOAD_X:  if (bus.valid_input && r_last && k_last) state_d = S_COMPUTE;
            S_COMPUTE: if (r_last && c_last && k_last) state_d = S_READY;
            S_READY:   if (!bus.read_n && r_last && c_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            k_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            finish_q <= 1'b0;
            sat_q    <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    c_mem_q[i][j] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_in && !bus.mode_in) sat_q <= 1'b0;
                end
                S_LOAD_C: begin
                    if (bus.valid_input) begin
                        c_mem_q[k_q][c_q] <= bus.X_load[COEF_W-1:0];
                        c_q <= c_last ? '0 : c_q + 1'b1;
                        if (c_last) k_q <= k_last ? '0 : k_q + 1'b1;
                    end
                end
                S_LOAD_X: begin
                    if (bus.valid_input) begin
                        k_q <= k_last ? '0 : k_q + 1'b1;
                        if (k_last) r_q <= r_last ? '0 : r_q + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    acc_q <= acc_d;
                    if (k_last) begin
                        k_q <= '0;
                        if (sat) sat_q <= 1'b1;
                        c_q <= c_last ? '0 : c_q + 1'b1;
                        if (c_last) begin
                            r_q <= r_last ? '0 : r_q + 1'b1;
                            if (r_last) finish_q <= 1'b1;
                        end
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_READY: begin
                    if (!bus.read_n) begin
                        rdata_q <= res_q[r_q][c_q];
                        c_q <= c_last ? '0 : c_q + 1'b1;
                        if (c_last) r_q <= r_last ? '0 : r_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // X and result buffers are always fully rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_LOAD_X && bus.valid_input)
            x_mem_q[r_q][k_q] <= bus.X_load;
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_COMPUTE && k_last)
            res_q[r_q][c_q] <= res_val;
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ry        = (state_q == S_READY);
    assign bus.finish    = finish_q;
    assign bus.sat_flag  = sat_q;
    assign bus.read_data = rdata_q;
endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: default 4x8x4 instance plus a 2x3x5 / OUT_W=10 instance.
// Ports: none; drives both interface instances, compares against hand values and a small model.
module tb_matmul_engine;
    localparam int R  = 4;
    localparam int KK = 8;
    localparam int CC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_engine_if #(.DATA_W(8), .OUT_W(16)) bus_a ();
    matmul_engine_if #(.DATA_W(8), .OUT_W(10)) bus_b ();

    matmul_engine #(.ROWS(4), .K(8), .COLS(4), .DATA_W(8), .COEF_W(8), .OUT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    matmul_engine #(.ROWS(2), .K(3), .COLS(5), .DATA_W(8), .COEF_W(8), .OUT_W(10))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int cm [KK][CC];
    int xm [R][KK];
    int em [R*CC];

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus_a.start_in = 0; bus_a.mode_in = 0; bus_a.valid_input = 0; bus_a.X_load = 0; bus_a.read_n = 1;
        bus_b.start_in = 0; bus_b.mode_in = 0; bus_b.valid_input = 0; bus_b.X_load = 0; bus_b.read_n = 1;
    endtask

    task automatic model_a;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < CC; c++) begin
                int s = 0;
                for (int k = 0; k < KK; k++) s += xm[r][k] * cm[k][c];
                em[r*CC+c] = (s > 65535) ? 65535 : s;
            end
        end
    endtask

    task automatic load_c_a;
        // valid_input in the start cycle carries a decoy that must not be captured
        bus_a.start_in = 1; bus_a.mode_in = 1; bus_a.valid_input = 1; bus_a.X_load = 8'd77;
        tick;
        bus_a.start_in = 0; bus_a.mode_in = 0;
        check("busy_after_start_c", bus_a.busy, 1);
        for (int k = 0; k < KK; k++) begin
            for (int c = 0; c < CC; c++) begin
                bus_a.valid_input = 1; bus_a.X_load = 8'(cm[k][c]);
                tick;
            end
        end
        bus_a.valid_input = 0;
        check("idle_after_c_load", bus_a.busy, 0);
    endtask

    task automatic load_x_a(input bit gaps, input bit poke);
        bus_a.start_in = 1; bus_a.mode_in = 0; bus_a.valid_input = 1; bus_a.X_load = 8'd200;
        tick;
        bus_a.start_in = 0;
        check("busy_after_start_x", bus_a.busy, 1);
        check("sat_clear_on_start", bus_a.sat_flag, 0);
        for (int r = 0; r < R; r++) begin
            for (int k = 0; k < KK; k++) begin
                if (gaps) begin
                    bus_a.valid_input = 0; bus_a.X_load = 8'd250;
                    tick;
                end
                bus_a.valid_input = 1; bus_a.X_load = 8'(xm[r][k]);
                if (poke && r == 1 && k == 0) begin
                    bus_a.start_in = 1; bus_a.mode_in = 1;
                end
                tick;
                bus_a.start_in = 0; bus_a.mode_in = 0;
            end
        end
        bus_a.valid_input = 0;
    endtask

    task automatic wait_finish_a(input int exp_cyc, input bit poke);
        int n = 0;
        while (!bus_a.finish && n < 1000) begin
            bus_a.start_in = (poke && n == 10);
            tick;
            n++;
        end
        bus_a.start_in = 0;
        check("compute_cycles", n, exp_cyc);
        check("ry_at_finish", bus_a.ry, 1);
        check("busy_at_finish", bus_a.busy, 1);
        tick;
        check("finish_one_cycle", bus_a.finish, 0);
        check("ry_after_finish", bus_a.ry, 1);
    endtask

    task automatic read_a(input int pace);
        logic [15:0] prev;
        for (int i = 0; i < R*CC; i++) begin
            for (int p = 1; p < pace; p++) begin
                bus_a.read_n = 1; bus_a.valid_input = 1; bus_a.X_load = 8'hA5;
                prev = bus_a.read_data;
                tick;
                check("hold_between_reads", bus_a.read_data, prev);
            end
            bus_a.read_n = 0; bus_a.valid_input = 0;
            tick;
            check("read_data", bus_a.read_data, em[i]);
            check("ry_during_read", bus_a.ry, (i < R*CC-1));
        end
        check("idle_after_reads", bus_a.busy, 0);
        // read_n in IDLE must not disturb the last value
        tick;
        bus_a.read_n = 1;
        check("read_data_holds", bus_a.read_data, em[R*CC-1]);
        check("ry_stays_low", bus_a.ry, 0);
    endtask

    task automatic run_b(input int hi);
        int cb [3][5];
        int xb [2][3];
        int eb [10];
        int n;
        bit any_sat = 0;
        for (int k = 0; k < 3; k++) for (int c = 0; c < 5; c++) cb[k][c] = $urandom_range(0, hi);
        for (int r = 0; r < 2; r++) for (int k = 0; k < 3; k++) xb[r][k] = $urandom_range(0, hi);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 5; c++) begin
                int s = 0;
                for (int k = 0; k < 3; k++) s += xb[r][k] * cb[k][c];
                if (s > 1023) any_sat = 1;
                eb[r*5+c] = (s > 1023) ? 1023 : s;
            end
        end
        bus_b.start_in = 1; bus_b.mode_in = 1;
        tick;
        bus_b.start_in = 0; bus_b.mode_in = 0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 5; c++) begin
                bus_b.valid_input = 1; bus_b.X_load = 8'(cb[k][c]);
                tick;
            end
        end
        bus_b.valid_input = 0;
        bus_b.start_in = 1;
        tick;
        bus_b.start_in = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                bus_b.valid_input = 1; bus_b.X_load = 8'(xb[r][k]);
                tick;
            end
        end
        bus_b.valid_input = 0;
        n = 0;
        while (!bus_b.finish && n < 500) begin
            tick;
            n++;
        end
        check("b_compute_cycles", n, 30);
        for (int i = 0; i < 10; i++) begin
            bus_b.read_n = 0;
            tick;
            check("b_read_data", bus_b.read_data, eb[i]);
        end
        bus_b.read_n = 1;
        check("b_ry_done", bus_b.ry, 0);
        check("b_sat_flag", bus_b.sat_flag, any_sat);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick;
        tick;
        rst = 0;
        check("rst_busy", bus_a.busy, 0);
        check("rst_ry", bus_a.ry, 0);
        check("rst_finish", bus_a.finish, 0);
        check("rst_sat", bus_a.sat_flag, 0);
        check("rst_read_data", bus_a.read_data, 0);
        check("rst_b_busy", bus_b.busy, 0);

        // strobes in IDLE do nothing
        bus_a.valid_input = 1; bus_a.X_load = 8'd9; bus_a.read_n = 0;
        tick;
        idle_inputs();
        check("idle_ignore_busy", bus_a.busy, 0);
        check("idle_ignore_ry", bus_a.ry, 0);
        check("idle_ignore_rdata", bus_a.read_data, 0);

        // C all ones, X row r = r+1 -> every result in row r is 8*(r+1)
        for (int k = 0; k < KK; k++) for (int c = 0; c < CC; c++) cm[k][c] = 1;
        for (int r = 0; r < R; r++) for (int k = 0; k < KK; k++) xm[r][k] = r + 1;
        for (int i = 0; i < R*CC; i++) em[i] = 8 * (i / CC + 1);
        load_c_a();
        load_x_a(0, 0);
        wait_finish_a(128, 0);
        read_a(1);
        check("sat_low_small", bus_a.sat_flag, 0);

        // paced load/read with stray start/valid pulses in non-accepting states
        for (int k = 0; k < KK; k++) for (int c = 0; c < CC; c++) cm[k][c] = (k*CC + c) * 7 + 3;
        for (int r = 0; r < R; r++) for (int k = 0; k < KK; k++) xm[r][k] = (r*KK + k) * 5 + 1;
        model_a();
        load_c_a();
        load_x_a(1, 1);
        wait_finish_a(128, 1);
        read_a(3);

        // C persists: new X only
        for (int r = 0; r < R; r++) for (int k = 0; k < KK; k++) xm[r][k] = r + k;
        model_a();
        load_x_a(0, 0);
        wait_finish_a(128, 0);
        read_a(1);

        // saturation: 8 * 255 * 255 = 520200 clamps to 65535
        for (int k = 0; k < KK; k++) for (int c = 0; c < CC; c++) cm[k][c] = 255;
        for (int r = 0; r < R; r++) for (int k = 0; k < KK; k++) xm[r][k] = 255;
        for (int i = 0; i < R*CC; i++) em[i] = 65535;
        load_c_a();
        load_x_a(0, 0);
        wait_finish_a(128, 0);
        read_a(1);
        check("sat_sticky", bus_a.sat_flag, 1);

        // reset at MAC cycle 50 clears C; the next run must produce zeros
        for (int r = 0; r < R; r++) for (int k = 0; k < KK; k++) xm[r][k] = 1;
        load_x_a(0, 0);
        for (int i = 0; i < 50; i++) tick;
        check("busy_mid_compute", bus_a.busy, 1);
        rst = 1;
        tick;
        rst = 0;
        check("midrst_busy", bus_a.busy, 0);
        check("midrst_ry", bus_a.ry, 0);
        check("midrst_finish", bus_a.finish, 0);
        check("midrst_read_data", bus_a.read_data, 0);
        for (int r = 0; r < R; r++) for (int k = 0; k < KK; k++) xm[r][k] = r * k + 1;
        for (int k = 0; k < KK; k++) for (int c = 0; c < CC; c++) cm[k][c] = 0;
        model_a();
        load_x_a(0, 0);
        wait_finish_a(128, 0);
        read_a(1);

        // 2x3x5, OUT_W=10: small values stay exact, large values clamp to 1023
        run_b(15);
        run_b(255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised load/compute/readout engine: the next generation of the fixed 4x8 byte-matrix multiplier. It multiplies a ROWS x K input matrix X, streamed in one byte per valid cycle, by a K x COLS coefficient matrix C. Unlike the fixed version, C is loadable at run time rather than hard-wired, results are saturated to a configurable output width, and results are read back through a ready/strobe handshake. Controller FSM, operand buffers, a single sequential MAC and the result buffer all live in this block.

## Interface
- ROWS, 4, rows of X and of the result
- K, 8, columns of X = rows of C (inner dimension)
- COLS, 4, columns of C and of the result
- DATA_W, 8, width of X_load and of X elements
- COEF_W, 8, width of C elements; COEF_W <= DATA_W, taken from X_load[COEF_W-1:0]
- OUT_W, 16, result width; ACC_W = DATA_W+COEF_W+clog2(K) internal, OUT_W <= ACC_W
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start_in  in  1  one-cycle start request, sampled only in IDLE
- mode_in  in  1  sampled with start_in: 0 = load X then compute, 1 = load C only
- valid_input  in  1  X_load carries a valid element this cycle
- X_load  in  DATA_W  element data (X or C, per mode)
- read_n  in  1  active-low read strobe, effective only while ry=1
- busy  out  1  high in every state except IDLE
- ry  out  1  result buffer holds unread results
- read_data  out  OUT_W  last result read out (registered)
- finish  out  1  one-cycle pulse: compute complete
- sat_flag  out  1  sticky: at least one result saturated since last start with mode_in=0

## Operation
- States: IDLE, LOAD_C, LOAD_X, COMPUTE, READY.
- IDLE: start_in=1 && mode_in=1 -> LOAD_C; start_in=1 && mode_in=0 -> LOAD_X and clear sat_flag. valid_input in IDLE is ignored.
- LOAD_C: each valid_input cycle writes C[idx], with idx row-major (k*COLS+c) and counting 0..K*COLS-1. The edge writing the last element -> IDLE.
- LOAD_X: each valid_input cycle writes X[idx], with idx row-major (r*K+k) and counting 0..ROWS*K-1. The edge writing the last element -> COMPUTE.
- COMPUTE: one MAC per cycle, order r outer, c middle, k inner, acc = sum of X[r][k]*C[k][c]. All arithmetic is unsigned.
  - The k=0 cycle loads the product; other cycles accumulate.
  - On the k=K-1 cycle, result[r*COLS+c] is written. The value is min(acc, 2^OUT_W-1); saturation sets sat_flag.
  - After the final MAC edge -> READY.
- READY: on each edge with read_n=0, read_data <= result[ridx] and ridx++. The edge reading the last of ROWS*COLS results -> IDLE, with ry=0. read_data holds its value afterwards.
- start_in is ignored outside IDLE. valid_input is ignored outside LOAD_C/LOAD_X. read_n is ignored outside READY.
- C persists across computations until reloaded or reset.
- rst in any state: -> IDLE, and all counters, C and the accumulator cleared to 0. The X and result buffers need no reset.

## Timing
- Reset values: busy=0, ry=0, finish=0, sat_flag=0, read_data=0.
- busy rises the cycle after start_in is sampled. valid_input in the start_in cycle is not captured.
- LOAD_X lasts exactly ROWS*K valid cycles (gaps in valid_input allowed). COMPUTE lasts exactly ROWS*COLS*K cycles (128 at defaults).
- finish=1 and ry=1 in the first READY cycle. finish drops after one cycle; ry stays high until the last read edge.
- Read latency: read_data is valid the cycle after the read_n=0 cycle. Back-to-back reads are allowed every cycle.
- Reset mid-operation: outputs take their reset values the cycle after the rst edge. Partial loads are discarded.

## Test plan
- Coefficient load: load C all 1 (32 elements), then X with row r = r+1. Required: finish 128 cycles after the last X element; 16 reads give 8,8,8,8,16,16,16,16,24,…,32; sat_flag=0.
- Saturation: C all 255, X all 255. Required: every result = 65535 (true sum 520200) and sat_flag=1. A following start with mode_in=0 clears sat_flag.
- Handshake pacing: load X with valid_input toggled every other cycle, then read with read_n low every third cycle. Required: exactly 32 captures; read_data changes only on strobe edges; ry drops on the 16th read; results match a reference model.
- Ignored inputs: pulse start_in during LOAD_X and COMPUTE, assert valid_input in READY, and assert read_n=0 in IDLE. Required: no state change, no buffer corruption.
- Reset mid-COMPUTE: assert rst at MAC cycle 50. Required: next cycle busy=0, ry=0, finish=0. A subsequent X load gives results with C=0 (all zeros).
- Parameter sweep: ROWS=2, K=3, COLS=5, OUT_W=10 with random data. Required: compute time 30 cycles; results equal min(true product, 1023).
